// File: rtl/ps_filter_pkg.sv
// Shared definitions for the binary morphological mask filter.
//   mode_t  : operation selected at SOF (bypass / majority / erode / dilate)
//   state_t : filter sequencing states
//   k_is_legal() : window sizes the filter supports
package ps_filter_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_MAJ    = 2'b01,
      MODE_ERODE  = 2'b10,
      MODE_DILATE = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FILL  = 2'b01,
      S_RUN   = 2'b10,
      S_FLUSH = 2'b11
   } state_t;

   function automatic bit k_is_legal(input int k);
      return (k == 3) || (k == 5);
   endfunction

endpackage

// File: rtl/ps_mask_linebuf.sv
// 1-bit delay line, DEPTH entries deep. Each enabled cycle writes i_din and
// presents the bit written DEPTH enables earlier on o_dout. Contents are not
// cleared; only the pointer is reset.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (pointer only)
//   i_en   : advance the line
//   i_din  : incoming bit
//   o_dout : bit written DEPTH enables ago
module ps_mask_linebuf #(
   parameter int DEPTH = 640
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_din,
   output logic o_dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic          mem [DEPTH];
   logic [AW-1:0] ptr;

   assign o_dout = mem[ptr];

   always_ff @(posedge i_clk) begin
      if (i_en) mem[ptr] <= i_din;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)     ptr <= '0;
      else if (i_en) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   end

endmodule

// File: rtl/ps_morph_filter.sv
// KxK binary morphological filter on a 1-bit mask AXI-Stream with zero
// padding at the image borders and its own K-1 line buffers.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_mode, i_thresh      : operation and majority threshold, latched at SOF
//   i_tdata/tuser/tlast/tvalid, o_tready : input stream (tlast unused)
//   o_tdata/tuser/tlast/tvalid, i_tready : output stream, 1-deep slice
//   o_sof_err             : pulse when an SOF is accepted mid-frame
//
// state   | meaning
// S_IDLE  | dropping beats until an SOF is accepted
// S_FILL  | loading the window, no output yet
// S_RUN   | one output beat per accepted input beat
// S_FLUSH | input blocked, zeros injected until the last output is emitted
module ps_morph_filter
   import ps_filter_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int K     = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_mode,
   input  logic [4:0] i_thresh,
   input  logic       i_tdata,
   input  logic       i_tuser,
   input  logic       i_tlast,
   input  logic       i_tvalid,
   output logic       o_tready,
   output logic       o_tdata,
   output logic       o_tuser,
   output logic       o_tlast,
   output logic       o_tvalid,
   input  logic       i_tready,
   output logic       o_sof_err
);

   localparam int H  = (K - 1) / 2;
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   if (!k_is_legal(K)) begin : g_bad_k
      $error("ps_morph_filter: K must be 3 or 5");
   end

   state_t          state, state_nx;
   mode_t           mode_q;
   logic [4:0]      thresh_q;
   logic [XW-1:0]   in_x, out_x;
   logic [YW-1:0]   in_y, out_y;
   logic            slice_free, in_acc, sof_acc, shift, emit, px_in;
   logic            fill_done, in_last, out_last;
   logic            unused_tlast;

   // Row 0 is the newest line (dy=+H); bit K-1 of a row is the newest column (dx=+H).
   logic            col_new [K];
   logic [K-1:0]    win     [K];
   logic [K-1:0]    win_nx  [K];
   logic [K-1:0]    tap     [K];
   logic [K-1:0]    x_ok, y_ok;
   logic [4:0]      n_cnt;
   logic            centre, all_t, any_t, filt;

   assign unused_tlast = i_tlast;

   assign fill_done = (in_x == XW'(H)) && (in_y == YW'(H));
   assign in_last   = (in_x == XW'(IMG_W - 1)) && (in_y == YW'(IMG_H - 1));
   assign out_last  = (out_x == XW'(IMG_W - 1)) && (out_y == YW'(IMG_H - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (sof_acc) state_nx = S_FILL;
         S_FILL:  if (sof_acc) state_nx = S_FILL;
                  else if (in_acc && fill_done) state_nx = S_RUN;
         S_RUN:   if (sof_acc) state_nx = S_FILL;
                  else if (in_acc && in_last) state_nx = S_FLUSH;
         S_FLUSH: if (emit && out_last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / handshake ----------------
   always_comb begin
      slice_free = i_tready || !o_tvalid;
      o_tready   = slice_free && (state != S_FLUSH);
      in_acc     = i_tvalid && o_tready;
      sof_acc    = in_acc && i_tuser;
      shift      = 1'b0;
      emit       = 1'b0;
      px_in      = i_tdata;
      case (state)
         S_IDLE:  shift = sof_acc;
         S_FILL:  begin
            shift = in_acc;
            emit  = in_acc && !i_tuser && fill_done;
         end
         S_RUN:   begin
            shift = in_acc;
            emit  = in_acc && !i_tuser;
         end
         S_FLUSH: begin
            px_in = 1'b0;
            shift = slice_free;
            emit  = slice_free;
         end
         default: ;
      endcase
   end

   // ---------------- counters and SOF latches ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         in_x     <= '0;
         in_y     <= '0;
         out_x    <= '0;
         out_y    <= '0;
         mode_q   <= MODE_BYPASS;
         thresh_q <= '0;
      end else if (sof_acc) begin
         // the SOF beat itself is pixel (0,0)
         in_x     <= XW'(1);
         in_y     <= '0;
         out_x    <= '0;
         out_y    <= '0;
         mode_q   <= mode_t'(i_mode);
         thresh_q <= i_thresh;
      end else begin
         if (in_acc && (state != S_IDLE)) begin
            if (in_x == XW'(IMG_W - 1)) begin
               in_x <= '0;
               in_y <= (in_y == YW'(IMG_H - 1)) ? '0 : in_y + 1'b1;
            end else begin
               in_x <= in_x + 1'b1;
            end
         end
         if (emit) begin
            if (out_x == XW'(IMG_W - 1)) begin
               out_x <= '0;
               out_y <= (out_y == YW'(IMG_H - 1)) ? '0 : out_y + 1'b1;
            end else begin
               out_x <= out_x + 1'b1;
            end
         end
      end
   end

   // ---------------- line buffers and window ----------------
   assign col_new[0] = px_in;

   for (genvar j = 0; j < K - 1; j++) begin : g_lb
      ps_mask_linebuf #(.DEPTH(IMG_W)) u_lb (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_en   (shift),
         .i_din  (col_new[j]),
         .o_dout (col_new[j+1])
      );
   end

   // The filter works on the window as it will look after this shift, so the
   // result is registered on the same edge that accepts the input pixel.
   always_comb begin
      for (int r = 0; r < K; r++) win_nx[r] = {col_new[r], win[r][K-1:1]};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int r = 0; r < K; r++) win[r] <= '0;
      end else if (shift) begin
         for (int r = 0; r < K; r++) win[r] <= win_nx[r];
      end
   end

   // Padding masks out-of-frame taps, which also hides stale line-buffer
   // contents and the wrap from one row's end into the next.
   always_comb begin
      for (int c = 0; c < K; c++)
         x_ok[c] = (int'(out_x) + c - H >= 0) && (int'(out_x) + c - H < IMG_W);
      for (int r = 0; r < K; r++)
         y_ok[r] = (int'(out_y) + H - r >= 0) && (int'(out_y) + H - r < IMG_H);
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            tap[r][c] = win_nx[r][c] && x_ok[c] && y_ok[r];
   end

   always_comb begin
      centre = tap[H][H];
      n_cnt  = '0;
      all_t  = 1'b1;
      any_t  = 1'b0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            all_t = all_t && tap[r][c];
            any_t = any_t || tap[r][c];
            if (!((r == H) && (c == H))) n_cnt = n_cnt + 5'(tap[r][c]);
         end
      end
      case (mode_q)
         MODE_BYPASS: filt = centre;
         MODE_MAJ:    filt = centre && (n_cnt >= thresh_q);
         MODE_ERODE:  filt = all_t;
         MODE_DILATE: filt = any_t;
         default:     filt = centre;
      endcase
   end

   // ---------------- output slice ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_tvalid  <= 1'b0;
         o_tdata   <= 1'b0;
         o_tuser   <= 1'b0;
         o_tlast   <= 1'b0;
         o_sof_err <= 1'b0;
      end else begin
         o_sof_err <= sof_acc && (state != S_IDLE);
         if (emit) begin
            o_tvalid <= 1'b1;
            o_tdata  <= filt;
            o_tuser  <= (out_x == '0) && (out_y == '0);
            o_tlast  <= (out_x == XW'(IMG_W - 1));
         end else if (i_tready) begin
            o_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps_morph_filter.sv
// Scoreboard bench for ps_morph_filter: an 8x6 K=3 instance and an 8x6 K=5
// instance share the input stream, sel5 picks which one receives beats.
module tb_ps_morph_filter;

   localparam int W    = 8;
   localparam int HT   = 6;
   localparam int NPIX = W * HT;

   typedef struct {
      string name;
      int    act;
      int    exp;
   } chk_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'b00;
   logic [4:0] thresh = 5'd0;
   logic       tdata = 1'b0, tuser = 1'b0, tlast = 1'b0, tvalid = 1'b0;
   logic       tready = 1'b1;
   logic       sel5 = 1'b0;
   bit         rdy_stall = 1'b0;

   logic rdy3, d3, u3, l3, v3, e3;
   logic rdy5, d5, u5, l5, v5, e5;

   chk_t       chk_q[$];
   logic [3:0] exp_q[$];   // {final, data, user, last}

   int n_chk = 0, n_bad = 0, mon_idx = 0;
   int cyc = 0, ones_cnt = 0, sof_err_cnt = 0, sof_out_cyc = -1;
   int flush_viol = 0, full_sent = 0, flush_done = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      tready = rdy_stall ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   ps_morph_filter #(.IMG_W(W), .IMG_H(HT), .K(3)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_thresh(thresh),
      .i_tdata(tdata), .i_tuser(tuser), .i_tlast(tlast), .i_tvalid(tvalid && !sel5),
      .o_tready(rdy3), .o_tdata(d3), .o_tuser(u3), .o_tlast(l3), .o_tvalid(v3),
      .i_tready(tready), .o_sof_err(e3));

   ps_morph_filter #(.IMG_W(W), .IMG_H(HT), .K(5)) dut5 (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_thresh(thresh),
      .i_tdata(tdata), .i_tuser(tuser), .i_tlast(tlast), .i_tvalid(tvalid && sel5),
      .o_tready(rdy5), .o_tdata(d5), .o_tuser(u5), .o_tlast(l5), .o_tvalid(v5),
      .i_tready(tready), .o_sof_err(e5));

   // monitor: all comparisons happen here
   always @(negedge clk) begin
      logic cv, cd, cu, cl, cr;
      logic [3:0] e;
      chk_t c;
      cv = sel5 ? v5 : v3;
      cd = sel5 ? d5 : d3;
      cu = sel5 ? u5 : u3;
      cl = sel5 ? l5 : l3;
      cr = sel5 ? rdy5 : rdy3;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         n_chk++;
         if (c.act != c.exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", c.name, c.act, c.exp);
         end
      end
      if (!rst) begin
         if (e3 || e5) sof_err_cnt++;
         if (full_sent != flush_done) begin
            if (cv && exp_q.size() > 0 && exp_q[0][3]) flush_done++;
            else if (cr) flush_viol++;
         end
         if (cv && tready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL extra_beat %0d: got d=%0d u=%0d l=%0d want no beat",
                        mon_idx, cd, cu, cl);
            end else begin
               e = exp_q.pop_front();
               if ({cd, cu, cl} != e[2:0]) begin
                  n_bad++;
                  $display("FAIL beat %0d: got d=%0d u=%0d l=%0d want d=%0d u=%0d l=%0d",
                           mon_idx, cd, cu, cl, e[2], e[1], e[0]);
               end
               if (cd) ones_cnt++;
               if (e[1]) sof_out_cyc = cyc;
            end
            mon_idx++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want test done");
      $fatal(1, "watchdog");
   end

   task automatic post(input string nm, input int a, input int e);
      chk_t c;
      c.name = nm;
      c.act  = a;
      c.exp  = e;
      chk_q.push_back(c);
   endtask

   function automatic bit ref_px(input logic [NPIX-1:0] img, input int x, input int y,
                                 input int md, input int thr, input int k);
      int h, n, xx, yy;
      bit t, c, all_t, any_t;
      h = (k - 1) / 2;
      n = 0;
      all_t = 1'b1;
      any_t = 1'b0;
      c = img[y*W + x];
      for (int dy = -h; dy <= h; dy++) begin
         for (int dx = -h; dx <= h; dx++) begin
            xx = x + dx;
            yy = y + dy;
            t = (xx >= 0 && xx < W && yy >= 0 && yy < HT) ? img[yy*W + xx] : 1'b0;
            all_t = all_t & t;
            any_t = any_t | t;
            if (dx != 0 || dy != 0) n += int'(t);
         end
      end
      case (md)
         0:       return c;
         1:       return c && (n >= thr);
         2:       return all_t;
         default: return any_t;
      endcase
   endfunction

   // Pushes the expected beats, then drives nb input beats (SOF on beat 0).
   // Non-SOF beats carry a different mode/threshold to show they are ignored.
   task automatic send_frame(input logic [NPIX-1:0] img, input int md, input int thr,
                             input int k, input int nb, input bit stall, output int acc_first);
      int h, n_out, tmo;
      logic [3:0] e;
      h = (k - 1) / 2;
      n_out = (nb >= NPIX) ? NPIX : nb - (h*W + h);
      for (int i = 0; i < n_out; i++) begin
         e = {i == NPIX - 1, ref_px(img, i % W, i / W, md, thr, k), i == 0, (i % W) == W - 1};
         exp_q.push_back(e);
      end
      acc_first = -1;
      for (int i = 0; i < nb; i++) begin
         if (stall && $urandom_range(0, 1) == 1) begin
            tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         tdata  = img[i];
         tuser  = (i == 0);
         tlast  = (i % W) == W - 1;
         mode   = (i == 0) ? 2'(md) : ~2'(md);
         thresh = (i == 0) ? 5'(thr) : 5'(thr ^ 7);
         tvalid = 1'b1;
         tmo = 0;
         @(negedge clk);
         while (!(sel5 ? rdy5 : rdy3) && tmo < 200) begin
            tmo++;
            @(negedge clk);
         end
         if (tmo >= 200) begin
            post("accept_timeout", tmo, 0);
            tvalid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (i == h*W + h) acc_first = cyc;
         if (i == NPIX - 1) full_sent++;
      end
      tvalid = 1'b0;
      tuser  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      post("drain_left", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int a9, o0, e0, fv0, fd0;
      logic [NPIX-1:0] ones, img1, pat, pat2;
      ones = '1;
      img1 = '0;
      img1[3*W + 3] = 1'b1;
      pat  = 48'hB4E1_96C3_5A2D;
      pat2 = 48'h0F31_C8A6_7250;

      repeat (2) @(posedge clk);
      @(negedge clk);
      post("reset_out3", int'({v3, d3, u3, l3, e3}), 0);
      post("reset_out5", int'({v5, d5, u5, l5, e5}), 0);
      post("reset_ready3", int'(rdy3), 1);
      @(posedge clk);
      #1 rst = 1'b0;

      o0 = ones_cnt;
      send_frame(ones, 1, 5, 3, NPIX, 1'b0, a9);
      drain();
      post("allones_maj5_ones", ones_cnt - o0, 44);

      o0 = ones_cnt;
      send_frame(img1, 2, 0, 3, NPIX, 1'b0, a9);
      drain();
      post("dot_erode_ones", ones_cnt - o0, 0);
      o0 = ones_cnt;
      send_frame(img1, 3, 0, 3, NPIX, 1'b0, a9);
      drain();
      post("dot_dilate_ones", ones_cnt - o0, 9);
      o0 = ones_cnt;
      send_frame(img1, 1, 1, 3, NPIX, 1'b0, a9);
      drain();
      post("dot_maj1_ones", ones_cnt - o0, 0);

      o0 = ones_cnt;
      send_frame(pat, 0, 0, 3, NPIX, 1'b0, a9);
      drain();
      post("bypass_first_valid_cyc", sof_out_cyc, a9);
      post("bypass_ones", ones_cnt - o0, $countones(pat));

      send_frame(pat2, 3, 0, 3, NPIX, 1'b0, a9);
      drain();
      rdy_stall = 1'b1;
      fv0 = flush_viol;
      fd0 = flush_done;
      send_frame(pat2, 3, 0, 3, NPIX, 1'b1, a9);
      drain();
      rdy_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      post("stall_flush_ready_high", flush_viol - fv0, 0);
      post("stall_flush_seen", flush_done - fd0, 1);

      e0 = sof_err_cnt;
      send_frame(pat, 1, 3, 3, 20, 1'b0, a9);
      send_frame(pat2, 2, 0, 3, NPIX, 1'b0, a9);
      drain();
      post("sof_err_pulses", sof_err_cnt - e0, 1);
      post("no_stray_sof_err", e0, 0);

      sel5 = 1'b1;
      send_frame(ones, 2, 0, 5, 5, 1'b0, a9);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      post("midreset_out5", int'({v5, d5, u5, l5, e5}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      post("postreset_out5", int'({v5, d5, u5, l5, e5}), 0);
      o0 = ones_cnt;
      send_frame(ones, 2, 0, 5, NPIX, 1'b0, a9);
      drain();
      post("k5_erode_ones", ones_cnt - o0, 8);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/ps_morph_filter.md
# ps_morph_filter

Parametrised successor to the fixed 3x3 red-mask filter. Accepts the raw 1-bit mask AXI-Stream from colour classification and owns its own K-1 line buffers, so it needs no external window builder. It applies a selectable KxK binary morphological operation with zero padding at image borders, and emits a regenerated mask stream with SOF/EOL toward the centroid calculator.

## Interface
Parameters:
- IMG_W, 640, active pixels per line (≥ K)
- IMG_H, 480, lines per frame (≥ K)
- K, 3, window size; legal values 3 or 5; H = (K-1)/2

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_mode  in  2  00 bypass, 01 majority, 10 erode, 11 dilate; latched at accepted SOF
- i_thresh  in  5  majority neighbour threshold (0..K*K-1); latched at accepted SOF
- i_tdata  in  1  mask pixel
- i_tuser  in  1  SOF
- i_tlast  in  1  EOL; ignored, line length comes from IMG_W
- i_tvalid  in  1  input valid
- o_tready  out  1  input ready
- o_tdata  out  1  filtered mask
- o_tuser  out  1  SOF, asserted on output pixel (0,0)
- o_tlast  out  1  EOL, asserted on output x = IMG_W-1
- o_tvalid  out  1  output valid
- i_tready  in  1  output ready
- o_sof_err  out  1  one-cycle pulse when i_tuser is accepted mid-frame

## Operation
- States:
  - IDLE: waits for an accepted beat with i_tuser=1. Non-SOF beats are accepted and dropped.
  - FILL: accepts input. Input counters in_x/in_y advance per accepted beat. No output until in index = H*IMG_W+H.
  - RUN: each accepted input beat produces one output beat.
  - FLUSH: entered after input (IMG_W-1, IMG_H-1) is accepted. Holds o_tready=0. Injects zero pixels internally, one per output advance, until output (IMG_W-1, IMG_H-1) is emitted, then returns to IDLE.
- Window:
  - The KxK shift window is fed from K-1 line buffers plus the live pixel.
  - Output counters out_x/out_y give the centre coordinate.
  - Tap (dx,dy) is forced to 0 when out_x+dx or out_y+dy falls outside [0,IMG_W-1]/[0,IMG_H-1]. This is zero padding and also masks stale buffer contents and row wrap.
- Ops (c = centre, n = count of the K*K-1 neighbours, width 5 bits):
  - bypass: c
  - majority: c && n ≥ thresh
  - erode: AND of all K*K padded taps
  - dilate: OR of all K*K taps
- An accepted i_tuser while not in IDLE:
  - pulses o_sof_err
  - discards the partial frame, with no further output beats for it
  - restarts FILL with that beat as pixel (0,0)
  - The output slice's pending beat, if any, is still delivered.
- i_mode/i_thresh changes mid-frame have no effect until the next accepted SOF.

## Timing
- Reset: o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0, o_sof_err=0, state IDLE, counters 0. Line buffer RAM is not cleared; padding masks it.
- o_tready = (i_tready || !o_tvalid) && state != FLUSH.
- Output is a 1-deep register slice. Data is held stable while o_tvalid && !i_tready.
- Latency: output pixel (x,y) becomes valid the cycle after input index y*IMG_W+x+H*IMG_W+H is accepted. In FLUSH, one beat per cycle while i_tready=1.
- Per frame: exactly IMG_W*IMG_H output beats, IMG_H tlasts, one tuser.
- A SOF accepted in the same cycle FLUSH finishes is impossible, because o_tready=0 in FLUSH. The next SOF is accepted the cycle after the return to IDLE.
- Reset mid-frame takes effect on the next edge and overrides all handshakes.

## Structure
- Shared package ps_filter_pkg holds:
  - mode encodings (MODE_BYPASS/MAJ/ERODE/DILATE)
  - state encodings (S_IDLE/S_FILL/S_RUN/S_FLUSH)
  - legal-K check
- Sub-module ps_mask_linebuf: a 1-bit wide, IMG_W deep delay line with a single enable, instantiated K-1 times and chained.
- Window, counters, FSM and output slice stay in the top level.

## Test plan
IMG_W=8, IMG_H=6, K=3 unless stated.
- All-ones frame, majority, thresh=5 -> all 48 outputs 1 except the four corners, which are 0.
- Single 1 at (3,3):
  - erode -> all 0
  - dilate -> 1 exactly at x,y∈{2,3,4}
  - majority thresh=1 -> all 0
- Bypass, i_tready held 1 -> first o_tvalid the cycle after input beat 9 is accepted; outputs equal inputs; tuser on beat 0, tlast on beats 7,15,…,47.
- Random 50% stalls on both i_tvalid and i_tready, dilate -> output sequence bit-identical to the no-stall run; 48 beats; o_tready=0 throughout FLUSH.
- SOF reinjected at input beat 20, then a full frame -> one o_sof_err pulse; 48 correct beats for the second frame only.
- K=5, all-ones, erode -> 1 only at x∈{2..5}, y∈{2..3}; reset asserted mid-FILL then a full frame -> all outputs zero after reset, then a clean 48-beat frame.
